// File: rtl/bloom_filter_pkg.sv
// Shared types and default sizing for the Bloom-filter hash LUT controller.
package bloom_filter_pkg;

  localparam int unsigned LUT_ADDR_W_DEFAULT = 10;
  localparam int unsigned LUT_DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {IDLE, CLEAN, RD, WR} lut_ctrl_state_t;

  // A hash value addresses one bit: word address on top, bit-in-word below.
  function automatic int unsigned hash_w(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + $clog2(data_w);
  endfunction

endpackage

// File: rtl/bloom_filter_lut_ctrl_if.sv
// Set-index stream and LUT RAM write/read port of the Bloom-filter LUT controller.
// master: the controller; slave: the loader/RAM side.
interface bloom_filter_lut_ctrl_if
  import bloom_filter_pkg::*;
#(
  parameter int unsigned LUT_ADDR_W = LUT_ADDR_W_DEFAULT,
  parameter int unsigned LUT_DATA_W = LUT_DATA_W_DEFAULT
);

  localparam int unsigned HASH_W = hash_w(LUT_ADDR_W, LUT_DATA_W);

  logic                  set_valid_i;
  logic                  set_ready_o;
  logic [HASH_W-1:0]     set_idx_i;
  logic [LUT_ADDR_W-1:0] ram_addr_o;
  logic                  ram_rd_o;
  logic [LUT_DATA_W-1:0] ram_rddata_i;
  logic                  ram_wr_o;
  logic [LUT_DATA_W-1:0] ram_wrdata_o;

  modport master (
    input  set_valid_i, set_idx_i, ram_rddata_i,
    output set_ready_o, ram_addr_o, ram_rd_o, ram_wr_o, ram_wrdata_o
  );

  modport slave (
    output set_valid_i, set_idx_i, ram_rddata_i,
    input  set_ready_o, ram_addr_o, ram_rd_o, ram_wr_o, ram_wrdata_o
  );

endinterface

// File: rtl/bloom_filter_lut_ctrl.sv
// Write-port sequencer for the Bloom-filter LUT: zero sweep after reset/clean, RMW bit sets.
// Optional BLOOM_FILTER_LUT_SET_CNT_EN adds set_cnt_o, a saturating count of newly set bits.
module bloom_filter_lut_ctrl
  import bloom_filter_pkg::*;
#(
  parameter int unsigned LUT_ADDR_W = LUT_ADDR_W_DEFAULT,
  parameter int unsigned LUT_DATA_W = LUT_DATA_W_DEFAULT
) (
  input  logic        clk_i,
  input  logic        srst_n_i,
  input  logic        clean_stb_i,
  output logic        clean_done_o,
`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
  output logic [31:0] set_cnt_o,
`endif
  bloom_filter_lut_ctrl_if.master bus
);

  localparam int unsigned HASH_W = hash_w(LUT_ADDR_W, LUT_DATA_W);
  localparam int unsigned BIT_W  = $clog2(LUT_DATA_W);
  localparam logic [LUT_ADDR_W-1:0] LAST_ADDR = '1;

  lut_ctrl_state_t       state_q;
  logic [LUT_ADDR_W-1:0] sweep_q;
  logic [LUT_ADDR_W-1:0] word_q;
  logic [BIT_W-1:0]      bit_q;

  // clean_stb_i overrides everything, including an in-flight set.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= CLEAN;
      sweep_q <= '0;
      word_q  <= '0;
      bit_q   <= '0;
    end else if (clean_stb_i) begin
      state_q <= CLEAN;
      sweep_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.set_valid_i) begin
            word_q  <= bus.set_idx_i[HASH_W-1 -: LUT_ADDR_W];
            bit_q   <= bus.set_idx_i[BIT_W-1:0];
            state_q <= RD;
          end
        end
        CLEAN: begin
          sweep_q <= sweep_q + LUT_ADDR_W'(1);
          if (sweep_q == LAST_ADDR) state_q <= IDLE;
        end
        RD:      state_q <= WR;
        WR:      state_q <= IDLE;
        default: state_q <= CLEAN;
      endcase
    end
  end

  assign clean_done_o = (state_q != CLEAN);

  always_comb begin
    bus.set_ready_o  = srst_n_i && (state_q == IDLE) && !clean_stb_i;
    bus.ram_rd_o     = (state_q == RD);
    bus.ram_wr_o     = 1'b0;
    bus.ram_addr_o   = word_q;
    bus.ram_wrdata_o = bus.ram_rddata_i | (LUT_DATA_W'(1) << bit_q);
    if (state_q == CLEAN) begin
      // Reset parks the state in CLEAN; hold the strobe off until reset is released.
      bus.ram_wr_o     = srst_n_i;
      bus.ram_addr_o   = sweep_q;
      bus.ram_wrdata_o = '0;
    end else if (state_q == WR) begin
      bus.ram_wr_o = !clean_stb_i;
    end
  end

`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
  logic [31:0] set_cnt_q;
  logic        new_bit;

  assign new_bit = !bus.ram_rddata_i[bit_q];

  always_ff @(posedge clk_i) begin
    if (!srst_n_i || clean_stb_i) begin
      set_cnt_q <= '0;
    end else if (state_q == WR && new_bit && set_cnt_q != '1) begin
      set_cnt_q <= set_cnt_q + 32'd1;
    end
  end

  assign set_cnt_o = set_cnt_q;
`endif

endmodule

// File: tb/tb_bloom_filter_lut_ctrl.sv
// Scoreboard bench for bloom_filter_lut_ctrl: expected RAM writes are queued by the stimulus and
// popped by a monitor; a bench-side LUT image and population count act as the reference.
module tb_bloom_filter_lut_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic        clk_i = 1'b0;
  logic        srst_n_i;
  logic        clean_stb_i;
  logic        clean_done_o;
`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
  logic [31:0] set_cnt_o;
`endif

  bloom_filter_lut_ctrl_if #(.LUT_ADDR_W(AW), .LUT_DATA_W(DW)) bus ();

  bloom_filter_lut_ctrl #(.LUT_ADDR_W(AW), .LUT_DATA_W(DW)) dut (
    .clk_i        (clk_i),
    .srst_n_i     (srst_n_i),
    .clean_stb_i  (clean_stb_i),
    .clean_done_o (clean_done_o),
`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
    .set_cnt_o    (set_cnt_o),
`endif
    .bus          (bus)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  wr_t exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ram [DEPTH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // RAM environment model: random power-up contents, one-cycle read latency.
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    bus.ram_rddata_i = DW'($urandom);
    forever begin
      @(posedge clk_i);
      if (bus.ram_wr_o) ram[bus.ram_addr_o] <= bus.ram_wrdata_o;
      if (bus.ram_rd_o) bus.ram_rddata_i <= ram[bus.ram_addr_o];
    end
  end

  // Monitor: every RAM write must match the next expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk_i);
      chk("rd_wr_exclusive", 32'(bus.ram_rd_o & bus.ram_wr_o), 32'd0);
      if (bus.ram_wr_o) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   bus.ram_addr_o, bus.ram_wrdata_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.ram_addr_o), 32'(e.addr));
          chk("wr_data", 32'(bus.ram_wrdata_o), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic int ref_pop();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += $countones(ref_mem[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_sweep(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{addr: AW'(i), data: '0});
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Called from the first CLEAN cycle; returns just after the last sweep edge.
  task automatic sweep_run(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_i);
      chk({name, "_done_low"}, 32'(clean_done_o), 32'd0);
      chk({name, "_ready_low"}, 32'(bus.set_ready_o), 32'd0);
      tick();
    end
  endtask

  task automatic check_done(input string name);
    @(negedge clk_i);
    chk({name, "_done_high"}, 32'(clean_done_o), 32'd1);
`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
    chk({name, "_cnt"}, set_cnt_o, 32'(ref_pop()));
`endif
    tick();
  endtask

  // Waits for acceptance; queues the expected write unless the set is about to be dropped.
  task automatic set_req(input logic [AW+2:0] idx, input bit hold, input bit push,
                         output int waits);
    logic [AW-1:0] w;
    logic [2:0]    b;
    bus.set_valid_i = 1'b1;
    bus.set_idx_i   = idx;
    waits = 0;
    @(negedge clk_i);
    while (!bus.set_ready_o && waits < 100) begin
      waits++;
      @(negedge clk_i);
    end
    if (!bus.set_ready_o) begin
      chk("set_accept_timeout", 32'(bus.set_ready_o), 32'd1);
    end else begin
      w = idx[AW+2:3];
      b = idx[2:0];
      if (push) begin
        ref_mem[w] = ref_mem[w] | (DW'(1) << b);
        exp_q.push_back('{addr: w, data: ref_mem[w]});
      end
    end
    tick();
    if (!hold) bus.set_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while (!bus.set_ready_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    chk("wait_idle_ready", 32'(bus.set_ready_o), 32'd1);
    tick();
  endtask

  initial begin
    int waits;
    logic [AW+2:0] idx;
    srst_n_i        = 1'b0;
    clean_stb_i     = 1'b0;
    bus.set_valid_i = 1'b0;
    bus.set_idx_i   = '0;

    // Reset values.
    tick();
    tick();
    @(negedge clk_i);
    chk("rst_done", 32'(clean_done_o), 32'd0);
    chk("rst_ready", 32'(bus.set_ready_o), 32'd0);
    chk("rst_rd", 32'(bus.ram_rd_o), 32'd0);
    chk("rst_wr", 32'(bus.ram_wr_o), 32'd0);
`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
    chk("rst_cnt", set_cnt_o, 32'd0);
`endif
    expect_sweep(DEPTH);
    @(posedge clk_i);
    #1 srst_n_i = 1'b1;
    sweep_run("post_reset");
    check_done("post_reset");

    // Single set with cycle-exact RMW timing.
    set_req(7'h2B, 1'b0, 1'b1, waits);
    @(negedge clk_i);
    chk("t1_rd", 32'(bus.ram_rd_o), 32'd1);
    chk("t1_addr", 32'(bus.ram_addr_o), 32'd5);
    chk("t1_ready", 32'(bus.set_ready_o), 32'd0);
    tick();
    @(negedge clk_i);
    chk("t2_wr", 32'(bus.ram_wr_o), 32'd1);
    chk("t2_data", 32'(bus.ram_wrdata_o), 32'h08);
    tick();
    @(negedge clk_i);
    chk("t3_ready", 32'(bus.set_ready_o), 32'd1);
    tick();

    // Back-to-back sets with valid held.
    set_req(7'h29, 1'b1, 1'b1, waits);
    set_req(7'h2B, 1'b0, 1'b1, waits);
    chk("b2b_wait_cycles", 32'(waits), 32'd2);
    wait_idle();
    chk("word5_after_b2b", 32'(ram[5]), 32'h0A);
`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
    chk("cnt_after_b2b", set_cnt_o, 32'd2);
`endif
    set_req(7'h2B, 1'b0, 1'b1, waits);
    wait_idle();
`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
    chk("cnt_after_repeat", set_cnt_o, 32'd2);
`endif

    // Clean during RD drops the in-flight set.
    set_req(7'h4E, 1'b0, 1'b0, waits);
    clean_stb_i = 1'b1;
    @(negedge clk_i);
    chk("rdclean_rd", 32'(bus.ram_rd_o), 32'd1);
    expect_sweep(DEPTH);
    tick();
    clean_stb_i = 1'b0;
`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
    chk("rdclean_cnt", set_cnt_o, 32'd0);
`endif
    sweep_run("rd_clean");
    check_done("rd_clean");

    // Clean and set together in IDLE: clean wins, set waits for the sweep.
    clean_stb_i     = 1'b1;
    bus.set_valid_i = 1'b1;
    bus.set_idx_i   = 7'h13;
    @(negedge clk_i);
    chk("collide_ready", 32'(bus.set_ready_o), 32'd0);
    expect_sweep(DEPTH);
    tick();
    clean_stb_i = 1'b0;
    sweep_run("collide");
    set_req(7'h13, 1'b0, 1'b1, waits);
    chk("collide_accept_wait", 32'(waits), 32'd0);
    wait_idle();

    // Clean restarted mid-sweep at address 9.
    clean_stb_i = 1'b1;
    expect_sweep(10);
    tick();
    clean_stb_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    clean_stb_i = 1'b1;
    expect_sweep(DEPTH);
    @(negedge clk_i);
    chk("restart_addr", 32'(bus.ram_addr_o), 32'd9);
    tick();
    clean_stb_i = 1'b0;
    sweep_run("restart");
    check_done("restart");

    // Random sets, random holds and gaps.
    for (int n = 0; n < 24; n++) begin
      idx = (AW + 3)'($urandom_range(0, (1 << (AW + 3)) - 1));
      set_req(idx, 1'($urandom_range(0, 1)), 1'b1, waits);
      if ($urandom_range(0, 2) == 0) begin
        bus.set_valid_i = 1'b0;
        tick();
      end
    end
    bus.set_valid_i = 1'b0;
    wait_idle();
    for (int i = 0; i < DEPTH; i++) chk($sformatf("final_word%0d", i), 32'(ram[i]), 32'(ref_mem[i]));
`ifdef BLOOM_FILTER_LUT_SET_CNT_EN
    chk("final_cnt", set_cnt_o, 32'(ref_pop()));
`endif
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bloom_filter_lut_ctrl.md
Name: bloom_filter_lut_ctrl

Overview:
Sequencer and arbiter for the single write port of the Bloom-filter hash LUT RAM. It sweeps the whole LUT to zero on a clean request, and after every reset. It also performs read-modify-write bit-set operations for pattern loading. Sits between the CSR block (clean strobe/done) and the pattern loader (set-index stream) on one side, and the LUT RAM port on the other.

Parameters:
LUT_ADDR_W, 10, RAM word address width; LUT depth = 2**LUT_ADDR_W words
LUT_DATA_W, 32, RAM word width (bits per word; power of two)
HASH_W, LUT_ADDR_W+$clog2(LUT_DATA_W), bit-index width of a hash value

Ports:
clk_i  in  1  clock
srst_n_i  in  1  synchronous reset, active low
clean_stb_i  in  1  one-cycle request to zero the LUT
clean_done_o  out  1  high when no clean sweep is in progress
set_valid_i  in  1  set request valid
set_ready_o  out  1  set request accepted when valid && ready
set_idx_i  in  HASH_W  bit index to set; upper LUT_ADDR_W bits select the word, lower bits select the bit
ram_addr_o  out  LUT_ADDR_W  RAM word address
ram_rd_o  out  1  RAM read strobe; data returns on ram_rddata_i exactly 1 cycle later
ram_rddata_i  in  LUT_DATA_W  RAM read data
ram_wr_o  out  1  RAM write strobe
ram_wrdata_o  out  LUT_DATA_W  RAM write data

Behaviour:
- One clock (clk_i). Reset is synchronous and active-low (srst_n_i).
- States: IDLE, CLEAN, RD, WR.
- Reset: state=CLEAN, sweep addr=0. clean_done_o=0, ram_rd_o=0, ram_wr_o=0, set_ready_o=0. The LUT is zeroed automatically after every reset.
- CLEAN:
  - Each cycle: ram_wr_o=1, ram_addr_o=sweep addr, ram_wrdata_o=0, then addr++.
  - After writing addr 2**LUT_ADDR_W-1, go to IDLE.
  - Sweep takes exactly 2**LUT_ADDR_W cycles. No wrap; the addr counter is 1 bit wider, or a last flag is used.
- clean_done_o = (state != CLEAN). It is driven from the state register, so it is glitch-free.
- IDLE: set_ready_o = !clean_stb_i (combinational). set_ready_o is 0 in all other states.
- Set accepted in cycle T:
  - Register the word address and bit.
  - T+1, RD: ram_rd_o=1, ram_addr_o=word.
  - T+2, WR: ram_wr_o=1, same addr, ram_wrdata_o = ram_rddata_i | (1 << bit).
  - T+3: IDLE, ready again.
  - Maximum throughput is one set per 3 cycles.
  - Operations are strictly serialized, so back-to-back sets to the same word need no forwarding.
- clean_stb_i in any state: next state CLEAN with addr=0.
  - In RD/WR, the in-flight set is dropped with no RAM write that cycle. The set was already handshaken, so it is lost by design, since the clean zeroes it anyway.
  - In CLEAN: the sweep restarts from addr 0.
  - In IDLE with set_valid_i=1: clean wins and the set is not accepted.
- ram_rd_o and ram_wr_o are never high in the same cycle. Outside the listed cases both are 0 and ram_addr_o/ram_wrdata_o are don't-care.

Optional Feature:
BLOOM_FILTER_LUT_SET_CNT_EN
- Defined: adds output set_cnt_o [31:0], reset 0.
  - Increments in WR when the target bit of ram_rddata_i was 0 (newly set bit).
  - Saturates at 2**32-1.
  - Cleared to 0 on the cycle entering CLEAN, for either reset or clean_stb_i.
  - Gives population of the filter for CSR readout.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- bloom_filter_pkg gets:
  - typedef enum lut_ctrl_state_t {IDLE, CLEAN, RD, WR}
  - LUT_ADDR_W and LUT_DATA_W defaults
  - HASH_W derivation
- No sub-module. The sweep counter and RMW path are small enough to stay inline.

Test Plan:
(LUT_ADDR_W=4, LUT_DATA_W=8)
- Release reset -> ram_wr_o=1 with wrdata 0 for addrs 0..15 on 16 consecutive cycles. clean_done_o rises on cycle 17. set_ready_o=0 throughout.
- After clean, set idx 0x2B -> RD addr 5 at T+1. RAM returns 0x00. WR addr 5 data 0x08 at T+2. set_ready_o=1 at T+3.
- Sets idx 0x29 then 0x2B back-to-back with set_valid held -> second accepted at T+3. Word 5 ends at 0x0A. With BLOOM_FILTER_LUT_SET_CNT_EN: set_cnt_o=2, and a repeat of 0x2B leaves it at 2.
- clean_stb_i pulsed during the RD cycle of a set -> no write to that word. CLEAN starts at addr 0 next cycle. clean_done_o=0 for 16 cycles. set_cnt_o=0.
- clean_stb_i and set_valid_i both high in IDLE -> set_ready_o=0 that cycle and the sweep starts. The set is accepted in the first IDLE cycle after the sweep.
- clean_stb_i again at sweep addr 9 -> next write is addr 0. A full 16-write sweep follows before clean_done_o=1.
